// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch sequencer        |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package fetch_pkg;
   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] INST_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_next : next fetch PC select (hold / +4 / redirect / trap)    |
// | Option        : FETCH_MISALIGN_TRAP_EN                                |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module fetch_pc_next
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic [XLEN-1:0] i_fetch_pc,
   input  logic            i_advance,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_target,
   output logic [XLEN-1:0] o_pc_next,
   output logic            o_trap
);
`ifdef FETCH_MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = |i_redirect_target[1:0];
   assign o_trap       = i_redirect_valid && w_misaligned;

   always_comb begin
      o_pc_next = i_fetch_pc;
      if (i_redirect_valid) begin
         o_pc_next = w_misaligned ? TRAP_VEC : i_redirect_target;
      end else if (i_advance) begin
         o_pc_next = i_fetch_pc + INST_STEP;
      end
   end
`else
   // Without trapping, low target bits are simply dropped.
   logic w_unused_bits;
   assign w_unused_bits = ^{TRAP_VEC, i_redirect_target[1:0]};
   assign o_trap        = 1'b0;

   always_comb begin
      o_pc_next = i_fetch_pc;
      if (i_redirect_valid) begin
         o_pc_next = {i_redirect_target[XLEN-1:2], 2'b00};
      end else if (i_advance) begin
         o_pc_next = i_fetch_pc + INST_STEP;
      end
   end
`endif
endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer : PC register and single-outstanding imem fetch FSM   |
// | Option          : FETCH_MISALIGN_TRAP_EN                              |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            stall,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign_trap
);
   fetch_state_t    r_state, w_state_next;
   logic [XLEN-1:0] r_fetch_pc, w_pc_next;
   logic            r_kill, w_kill_next;
   logic            r_req_valid, r_inst_valid;
   logic [XLEN-1:0] r_inst_data, r_inst_pc;
   logic            w_capture, w_advance, w_trap;

   fetch_pc_next #(.TRAP_VEC(TRAP_VEC)) u_pc_next (
      .i_fetch_pc        (r_fetch_pc),
      .i_advance         (w_advance),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .o_pc_next         (w_pc_next),
      .o_trap            (w_trap)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_kill_next  = r_kill;
      w_capture    = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         IDLE: w_state_next = REQ;
         REQ: begin
            // A redirect coinciding with acceptance must kill that response.
            if (imem_req_ready) begin
               w_state_next = WAIT;
               w_kill_next  = redirect_valid;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               w_kill_next = 1'b0;
               if (redirect_valid || r_kill) begin
                  w_state_next = REQ;
               end else begin
                  w_state_next = HOLD;
                  w_capture    = 1'b1;
               end
            end else if (redirect_valid) begin
               w_kill_next = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               w_state_next = REQ;
            end else if (!stall) begin
               w_state_next = REQ;
               w_advance    = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc   <= RESET_PC;
         r_kill       <= 1'b0;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst_data  <= '0;
         r_inst_pc    <= '0;
      end else begin
         r_fetch_pc   <= w_pc_next;
         r_kill       <= w_kill_next;
         r_req_valid  <= (w_state_next == REQ);
         r_inst_valid <= (w_state_next == HOLD);
         if (w_capture) begin
            r_inst_data <= imem_resp_data;
            r_inst_pc   <= r_fetch_pc;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_trap;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_trap <= 1'b0;
      else          r_trap <= w_trap;
   end
   assign misalign_trap = r_trap;
`else
   logic w_unused_trap;
   assign w_unused_trap = w_trap;
   assign misalign_trap = 1'b0;
`endif

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign inst_valid     = r_inst_valid;
   assign inst_data      = r_inst_data;
   assign inst_pc        = r_inst_pc;
endmodule
`default_nettype wire
